seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Adds the datapath ALU's missing operations: signed radix-2 Booth multiply into a 2*WIDTH result and signed restoring divide (quotient/remainder).
- Adds variable-amount shifts/rotates, an arithmetic right shift, and a start/busy/done handshake so the control unit can stall on long operations.
- Sits between the A/B operand registers and the Z (ZHI/ZLO) registers.

Parameters:
WIDTH, 32, operand/result word width; even, >= 4
SHW, $clog2(WIDTH), shift-amount field width taken from B[SHW-1:0]

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, synchronous, active-high
start  in  1  operation request; sampled only in IDLE
ctrl  in  4  operation select, sampled with start
A  in  WIDTH  operand A, sampled with start
B  in  WIDTH  operand B / shift amount, sampled with start
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: ZHI/ZLO updated this cycle
dz  out  1  divide-by-zero flag, valid with done
ZHI  out  WIDTH  high result word / remainder
ZLO  out  WIDTH  low result word / quotient

Behaviour:
- Reset (clr=1 at a rising edge): state=IDLE, busy=0, done=0, dz=0, ZHI=0, ZLO=0, internal counters/accumulators=0.
- clr overrides everything, including mid-MUL/DIV: the operation is aborted and no done is issued.
- States: IDLE, MUL, DIV, FIN.
- start=1 in IDLE at edge E0 latches ctrl/A/B. start in any other state is ignored.
- Single-cycle ops complete at E0: results written, done=1 during the following cycle, ZHI=0 unless stated otherwise.
- Single-cycle op codes (ctrl):
  - 0000 ADD: ZLO = A+B, mod 2^WIDTH.
  - 0001 SUB: ZLO = A-B, mod 2^WIDTH.
  - 0100 SHR: logical right shift of A by B[SHW-1:0].
  - 0101 SHL: left shift of A by B[SHW-1:0].
  - 0110 ROR: rotate A right by B[SHW-1:0].
  - 0111 ROL: rotate A left by B[SHW-1:0].
  - 1000 AND: bitwise.
  - 1001 OR: bitwise.
  - 1010 NEG: two's complement, ZLO = -A.
  - 1011 NOT: bitwise, ZLO = ~A.
  - 1100 SHRA: arithmetic right shift of A by B[SHW-1:0].
  - 1101-1111: no-op; ZHI/ZLO hold, done still pulses.
- Shift amount 0: ZLO = A.
- 0010 MUL:
  - E0 -> MUL, busy=1.
  - Exactly WIDTH Booth iterations, one per edge, on signed A x signed B.
  - Then FIN: {ZHI,ZLO} = signed 2*WIDTH product, done=1, busy=0, return to IDLE.
  - Latency: done is high in the cycle after edge E0+WIDTH+1; busy is high for WIDTH+1 cycles.
- 0011 DIV:
  - Same timing as MUL.
  - Signed operation: magnitudes divided, then signs fixed up.
  - ZLO = quotient, truncated toward zero; ZHI = remainder, carrying the sign of the dividend.
  - B=0: no iteration. Completes like a single-cycle op with ZLO = all-ones, ZHI = A, dz=1.
  - Most-negative / -1: ZLO = most-negative, ZHI = 0; no trap.
- dz is cleared on the completion of any op other than a divide by zero.
- done is exactly one cycle. A new start is accepted in the done cycle (back-to-back throughput).
- ZHI/ZLO hold their last value until the next completion or clr.

Optional Feature:
- Macro: SEQ_ALU_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), valid with done.
  - ADD/SUB: ovf = signed overflow.
  - NEG: ovf = 1 iff A = most-negative.
  - MUL: ovf = 1 iff the product does not fit in WIDTH signed bits, i.e. ZHI is not the sign extension of ZLO.
  - DIV: ovf = 1 for most-negative / -1.
  - All other ops: ovf = 0.
- Undefined: the port is absent and no overflow logic is present; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=32.
- ADD: A=0x7FFFFFFF, B=1 -> ZLO=0x80000000, ZHI=0, done in the cycle after the start edge, busy never high; ovf=1 if SEQ_ALU_OVF_EN.
- MUL: A=0xFFFFFFFD (-3), B=7 -> ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB; busy high 33 cycles; done pulse 1 cycle; a start pulsed mid-op is ignored.
- DIV: A=-17, B=5 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE, dz=0, 33-cycle latency. Then A=9, B=0 -> ZLO=0xFFFFFFFF, ZHI=9, dz=1 after 1 cycle.
- Shifts: A=0x80000001, B=4:
  - ROL -> 0x00000018
  - ROR -> 0x18000000
  - SHR -> 0x08000000
  - SHRA -> 0xF8000000
  - SHL -> 0x00000010
  - B=0 -> ZLO=A
- NOT/NEG: A=5 -> NOT gives 0xFFFFFFFA, NEG gives 0xFFFFFFFB; back-to-back starts in done cycles are each accepted.
- clr asserted at MUL iteration 10 -> next cycle busy=0, done=0, ZHI=ZLO=0; no later done; a start the following cycle is accepted normally.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift ops, radix-2 Booth multiply and restoring divide.
// Optional signed-overflow output enabled by defining SEQ_ALU_OVF_EN.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] ZHI,
   output logic [WIDTH-1:0] ZLO
`ifdef SEQ_ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH:0]   acc_r;
   logic [WIDTH-1:0] q_r, m_r, zhi_r, zlo_r;
   logic             q1_r, is_div_r, neg_q_r, neg_r_r, busy_r, done_r, dz_r;

   logic             accept_s, multi_s, last_s, sc_upd_s, sc_dz_s;
   logic [SHW-1:0]   sh_s;
   logic [WIDTH-1:0] sc_hi_s, sc_lo_s, a_abs_s, b_abs_s;
   logic [WIDTH:0]   booth_sum_s, rsh_s, diff_s;

   assign accept_s = start && (state_r == IDLE);
   assign multi_s  = (ctrl == 4'b0010) || ((ctrl == 4'b0011) && (B != {WIDTH{1'b0}}));
   assign last_s   = (cnt_r == CW'(WIDTH - 1));
   assign sh_s     = B[SHW-1:0];
   assign a_abs_s  = A[WIDTH-1] ? -A : A;
   assign b_abs_s  = B[WIDTH-1] ? -B : B;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && multi_s) begin
               state_s = (ctrl == 4'b0010) ? MUL : DIV;
            end else begin
               state_s = IDLE;
            end
         end
         MUL:     state_s = last_s ? FIN : MUL;
         DIV:     state_s = last_s ? FIN : DIV;
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Single-cycle result selection; divide here only covers the B=0 case
   always_comb begin
      sc_upd_s = 1'b1;
      sc_dz_s  = 1'b0;
      sc_hi_s  = {WIDTH{1'b0}};
      sc_lo_s  = {WIDTH{1'b0}};
      case (ctrl)
         4'b0000: sc_lo_s = A + B;
         4'b0001: sc_lo_s = A - B;
         4'b0011: begin
            sc_lo_s = {WIDTH{1'b1}};
            sc_hi_s = A;
            sc_dz_s = 1'b1;
         end
         4'b0100: sc_lo_s = A >> sh_s;
         4'b0101: sc_lo_s = A << sh_s;
         4'b0110: sc_lo_s = (A >> sh_s) | (A << (WIDTH - int'(sh_s)));
         4'b0111: sc_lo_s = (A << sh_s) | (A >> (WIDTH - int'(sh_s)));
         4'b1000: sc_lo_s = A & B;
         4'b1001: sc_lo_s = A | B;
         4'b1010: sc_lo_s = -A;
         4'b1011: sc_lo_s = ~A;
         4'b1100: sc_lo_s = $signed(A) >>> sh_s;
         default: sc_upd_s = 1'b0;
      endcase
   end

   // Iteration datapath: Booth add/sub step and restoring-divide trial subtract
   always_comb begin
      case ({q_r[0], q1_r})
         2'b01:   booth_sum_s = acc_r + {m_r[WIDTH-1], m_r};
         2'b10:   booth_sum_s = acc_r - {m_r[WIDTH-1], m_r};
         default: booth_sum_s = acc_r;
      endcase
      rsh_s  = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
      diff_s = rsh_s - {1'b0, m_r};
   end

   // State, iteration registers and result registers
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         acc_r    <= {(WIDTH+1){1'b0}};
         q_r      <= {WIDTH{1'b0}};
         m_r      <= {WIDTH{1'b0}};
         q1_r     <= 1'b0;
         is_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dz_r     <= 1'b0;
         zhi_r    <= {WIDTH{1'b0}};
         zlo_r    <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         done_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s && multi_s) begin
                  busy_r   <= 1'b1;
                  cnt_r    <= {CW{1'b0}};
                  acc_r    <= {(WIDTH+1){1'b0}};
                  q1_r     <= 1'b0;
                  is_div_r <= ctrl[0];
                  neg_q_r  <= A[WIDTH-1] ^ B[WIDTH-1];
                  neg_r_r  <= A[WIDTH-1];
                  q_r      <= ctrl[0] ? a_abs_s : B;
                  m_r      <= ctrl[0] ? b_abs_s : A;
               end else if (accept_s) begin
                  done_r <= 1'b1;
                  dz_r   <= sc_dz_s;
                  if (sc_upd_s) begin
                     zhi_r <= sc_hi_s;
                     zlo_r <= sc_lo_s;
                  end
               end
            end
            MUL: begin
               acc_r <= {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
               q_r   <= {booth_sum_s[0], q_r[WIDTH-1:1]};
               q1_r  <= q_r[0];
               cnt_r <= cnt_r + CW'(1);
            end
            DIV: begin
               acc_r <= diff_s[WIDTH] ? rsh_s : diff_s;
               q_r   <= {q_r[WIDTH-2:0], ~diff_s[WIDTH]};
               cnt_r <= cnt_r + CW'(1);
            end
            FIN: begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
               dz_r   <= 1'b0;
               if (is_div_r) begin
                  zlo_r <= neg_q_r ? -q_r : q_r;
                  zhi_r <= neg_r_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
               end else begin
                  zlo_r <= q_r;
                  zhi_r <= acc_r[WIDTH-1:0];
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign dz   = dz_r;
   assign ZHI  = zhi_r;
   assign ZLO  = zlo_r;

`ifdef SEQ_ALU_OVF_EN
   logic ovf_r, div_ovf_r, sc_ovf_s;

   // Overflow for single-cycle ops
   always_comb begin
      sc_ovf_s = 1'b0;
      case (ctrl)
         4'b0000: sc_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sc_lo_s[WIDTH-1] != A[WIDTH-1]);
         4'b0001: sc_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (sc_lo_s[WIDTH-1] != A[WIDTH-1]);
         4'b1010: sc_ovf_s = (A == {1'b1, {(WIDTH-1){1'b0}}});
         default: sc_ovf_s = 1'b0;
      endcase
   end

   // Overflow register; divide overflow is decided from the operands at start
   always_ff @(posedge clk) begin
      if (clr) begin
         ovf_r     <= 1'b0;
         div_ovf_r <= 1'b0;
      end else if (accept_s && multi_s) begin
         div_ovf_r <= (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});
      end else if (accept_s) begin
         ovf_r <= sc_ovf_s;
      end else if (state_r == FIN) begin
         ovf_r <= is_div_r ? div_ovf_r : (acc_r[WIDTH-1:0] != {WIDTH{q_r[WIDTH-1]}});
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        clr, start;
   logic [3:0]  ctrl;
   logic [31:0] A, B;
   logic        busy, done, dz;
   logic [31:0] ZHI, ZLO;
`ifdef SEQ_ALU_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;
   int lat, bcnt, ndone;

   logic [3:0]  sh_op  [5] = '{4'b0111, 4'b0110, 4'b0100, 4'b1100, 4'b0101};
   logic [31:0] sh_exp [5] = '{32'h0000_0018, 32'h1800_0000, 32'h0800_0000,
                               32'hF800_0000, 32'h0000_0010};

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .clr(clr), .start(start), .ctrl(ctrl), .A(A), .B(B),
      .busy(busy), .done(done), .dz(dz), .ZHI(ZHI), .ZLO(ZLO)
`ifdef SEQ_ALU_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start edge E0 happens inside; returns 1ns after E0.
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; ctrl = c; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Samples each cycle after E0 until done, pulsing a stray start mid-op.
   task automatic wait_done(output int l, output int bc);
      l = 0; bc = 0;
      while (done !== 1'b1 && l < 100) begin
         if (busy === 1'b1) bc++;
         start = (l == 5);
         @(posedge clk); #1;
         l++;
      end
      start = 1'b0;
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; ctrl = 4'b0000; A = 32'h0; B = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dz",   dz,   1'b0);
      chk("rst_zhi",  ZHI,  32'h0);
      chk("rst_zlo",  ZLO,  32'h0);
      clr = 1'b0;

      issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
      chk("add_done", done, 1'b1);
      chk("add_busy", busy, 1'b0);
      chk("add_zlo",  ZLO,  32'h8000_0000);
      chk("add_zhi",  ZHI,  32'h0);
`ifdef SEQ_ALU_OVF_EN
      chk("add_ovf",  ovf,  1'b1);
`endif
      @(posedge clk); #1;
      chk("add_done_pulse", done, 1'b0);

      issue(4'b0010, 32'hFFFF_FFFD, 32'h7);
      wait_done(lat, bcnt);
      chk("mul_latency", lat,  33);
      chk("mul_busy_cy", bcnt, 33);
      chk("mul_zhi",     ZHI,  32'hFFFF_FFFF);
      chk("mul_zlo",     ZLO,  32'hFFFF_FFEB);
      chk("mul_busy_lo", busy, 1'b0);
`ifdef SEQ_ALU_OVF_EN
      chk("mul_ovf",     ovf,  1'b0);
`endif
      @(posedge clk); #1;
      chk("mul_done_pulse", done, 1'b0);

      issue(4'b0011, 32'hFFFF_FFEF, 32'h5);
      wait_done(lat, bcnt);
      chk("div_latency", lat, 33);
      chk("div_zlo",     ZLO, 32'hFFFF_FFFD);
      chk("div_zhi",     ZHI, 32'hFFFF_FFFE);
      chk("div_dz",      dz,  1'b0);

      issue(4'b0011, 32'h9, 32'h0);
      chk("div0_done", done, 1'b1);
      chk("div0_busy", busy, 1'b0);
      chk("div0_zlo",  ZLO,  32'hFFFF_FFFF);
      chk("div0_zhi",  ZHI,  32'h9);
      chk("div0_dz",   dz,   1'b1);

      for (int i = 0; i < 5; i++) begin
         issue(sh_op[i], 32'h8000_0001, 32'h4);
         chk($sformatf("shift%0d_zlo", i), ZLO, sh_exp[i]);
         chk($sformatf("shift%0d_zhi", i), ZHI, 32'h0);
         chk($sformatf("shift%0d_dz", i),  dz,  1'b0);
      end
      issue(4'b0111, 32'h8000_0001, 32'h0);
      chk("shift0_amt_zlo", ZLO, 32'h8000_0001);
      issue(4'b1101, 32'h1, 32'h2);
      chk("nop_done", done, 1'b1);
      chk("nop_hold", ZLO,  32'h8000_0001);

      @(negedge clk);
      start = 1'b1; ctrl = 4'b1011; A = 32'h5; B = 32'h0;
      @(posedge clk); #1;
      chk("not_done", done, 1'b1);
      chk("not_zlo",  ZLO,  32'hFFFF_FFFA);
      ctrl = 4'b1010;
      @(posedge clk); #1;
      start = 1'b0;
      chk("neg_b2b_done", done, 1'b1);
      chk("neg_zlo",      ZLO,  32'hFFFF_FFFB);

      issue(4'b0010, 32'hFFFF_FFFD, 32'h7);
      repeat (9) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_zhi",  ZHI,  32'h0);
      chk("abort_zlo",  ZLO,  32'h0);
      issue(4'b0001, 32'hA, 32'h3);
      chk("post_abort_done", done, 1'b1);
      chk("post_abort_zlo",  ZLO,  32'h7);
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      chk("abort_no_late_done", ndone, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
